// File: rtl/ltpi_selftest_runner.sv
// ltpi_selftest_runner
//   Launches up to NUM_TESTS LTPI PHY self-test engines, sequentially (lowest index first)
//   or all at once, with a per-test cycle timeout, and folds the results into
//   pass/fail/timeout masks plus a single suite verdict.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   start                        suite start pulse (accepted only when idle)
//   parallel_mode, stop_on_fail  run mode, latched at start
//   test_enable, timeout_cycles  channel enables and per-test timeout (0 = none), latched at start
//   tc_start / tc_done / tc_pass per-channel launch pulse, completion pulse and verdict
//   busy, done, result_valid     suite status
//   suite_pass                   overall verdict
//   pass_mask, fail_mask, timeout_mask, current_test, tests_run  result details
module ltpi_selftest_runner #(
   parameter int unsigned NUM_TESTS = 4,
   parameter int unsigned TO_W      = 16,
   parameter int unsigned IDX_W     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 parallel_mode,
   input  logic                 stop_on_fail,
   input  logic [NUM_TESTS-1:0] test_enable,
   input  logic [TO_W-1:0]      timeout_cycles,
   output logic [NUM_TESTS-1:0] tc_start,
   input  logic [NUM_TESTS-1:0] tc_done,
   input  logic [NUM_TESTS-1:0] tc_pass,
   output logic                 busy,
   output logic                 done,
   output logic                 suite_pass,
   output logic                 result_valid,
   output logic [NUM_TESTS-1:0] pass_mask,
   output logic [NUM_TESTS-1:0] fail_mask,
   output logic [NUM_TESTS-1:0] timeout_mask,
   output logic [IDX_W-1:0]     current_test,
   output logic [5:0]           tests_run
);

   typedef enum logic [2:0] {StIdle, StSeqLaunch, StSeqWait, StParWait, StReport} state_e;

   state_e               state_q, state_d;
   logic                 sof_q, sof_d;
   logic [NUM_TESTS-1:0] en_q, en_d;
   logic [TO_W-1:0]      to_q, to_d;
   logic [TO_W-1:0]      timer_q, timer_d;
   logic [IDX_W-1:0]     cur_q, cur_d;
   logic                 launch_q, launch_d;  // parallel launch cycle marker
   logic [NUM_TESTS-1:0] pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
   logic [5:0]           run_q, run_d;
   logic                 rv_q, rv_d;

   function automatic logic [5:0] popcnt(input logic [NUM_TESTS-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < int'(NUM_TESTS); i++) c = c + 6'(v[i]);
      return c;
   endfunction

   // Lowest enabled channel at start, and next enabled channel above the active one.
   logic [IDX_W-1:0] first_idx, next_idx;
   logic             next_any;
   always_comb begin
      first_idx = '0;
      next_idx  = '0;
      next_any  = 1'b0;
      for (int i = int'(NUM_TESTS) - 1; i >= 0; i--) begin
         if (test_enable[i]) first_idx = IDX_W'(i);
         if (en_q[i] && (i > int'(cur_q))) begin
            next_idx = IDX_W'(i);
            next_any = 1'b1;
         end
      end
   end

   // Timer counts the cycles after launch; expiry lands on the timeout_cycles-th of them.
   logic expire;
   assign expire = (to_q != '0) && (timer_q == (to_q - TO_W'(1)));

   logic                 seq_resolve, seq_failed;
   logic [NUM_TESTS-1:0] pending, par_new, par_stale, par_left;
   assign seq_resolve = tc_done[cur_q] | expire;
   assign seq_failed  = tc_done[cur_q] ? ~tc_pass[cur_q] : 1'b1;  // done beats expiry
   assign pending     = en_q & ~(pass_q | fail_q);
   assign par_new     = launch_q ? '0 : (tc_done & pending);
   assign par_stale   = (!launch_q && expire) ? (pending & ~par_new) : '0;
   assign par_left    = pending & ~par_new & ~par_stale;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (test_enable == '0) state_d = StReport;
               else if (parallel_mode) state_d = StParWait;
               else                    state_d = StSeqLaunch;
            end
         end
         StSeqLaunch: state_d = StSeqWait;
         StSeqWait: begin
            if (seq_resolve) begin
               if ((seq_failed && sof_q) || !next_any) state_d = StReport;
               else                                    state_d = StSeqLaunch;
            end
         end
         StParWait: if (!launch_q && (par_left == '0)) state_d = StReport;
         StReport:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      sof_d    = sof_q;
      en_d     = en_q;
      to_d     = to_q;
      cur_d    = cur_q;
      launch_d = 1'b0;
      timer_d  = timer_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      tmo_d    = tmo_q;
      run_d    = run_q;
      rv_d     = rv_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               sof_d    = stop_on_fail & ~parallel_mode;
               en_d     = test_enable;
               to_d     = timeout_cycles;
               cur_d    = parallel_mode ? '0 : first_idx;
               launch_d = parallel_mode && (test_enable != '0);
               timer_d  = '0;
               pass_d   = '0;
               fail_d   = '0;
               tmo_d    = '0;
               run_d    = '0;
               rv_d     = 1'b0;
            end
         end
         StSeqLaunch: timer_d = '0;
         StSeqWait: begin
            timer_d = timer_q + TO_W'(1);
            if (seq_resolve) begin
               run_d = run_q + 6'd1;
               if (!seq_failed) pass_d[cur_q] = 1'b1;
               else             fail_d[cur_q] = 1'b1;
               if (!tc_done[cur_q]) tmo_d[cur_q] = 1'b1;
               if (next_any && !(seq_failed && sof_q)) cur_d = next_idx;
            end
         end
         StParWait: begin
            timer_d = launch_q ? '0 : (timer_q + TO_W'(1));
            pass_d  = pass_q | (par_new & tc_pass);
            fail_d  = fail_q | (par_new & ~tc_pass) | par_stale;
            tmo_d   = tmo_q | par_stale;
            run_d   = run_q + popcnt(par_new | par_stale);
         end
         default: ;
      endcase
      if (state_d == StReport) rv_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sof_q    <= 1'b0;
         en_q     <= '0;
         to_q     <= '0;
         cur_q    <= '0;
         launch_q <= 1'b0;
         timer_q  <= '0;
         pass_q   <= '0;
         fail_q   <= '0;
         tmo_q    <= '0;
         run_q    <= '0;
         rv_q     <= 1'b0;
      end else begin
         sof_q    <= sof_d;
         en_q     <= en_d;
         to_q     <= to_d;
         cur_q    <= cur_d;
         launch_q <= launch_d;
         timer_q  <= timer_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         tmo_q    <= tmo_d;
         run_q    <= run_d;
         rv_q     <= rv_d;
      end
   end

   // Outputs
   always_comb begin
      tc_start = '0;
      if (state_q == StSeqLaunch)               tc_start[cur_q] = 1'b1;
      else if (state_q == StParWait && launch_q) tc_start        = en_q;
      busy       = (state_q == StSeqLaunch) || (state_q == StSeqWait) || (state_q == StParWait);
      done       = (state_q == StReport);
      suite_pass = rv_q && (fail_q == '0) && (run_q == popcnt(en_q)) && (run_q != '0);
   end

   assign result_valid = rv_q;
   assign pass_mask    = pass_q;
   assign fail_mask    = fail_q;
   assign timeout_mask = tmo_q;
   assign current_test = cur_q;
   assign tests_run    = run_q;

endmodule

// File: tb/tb_ltpi_selftest_runner.sv
module tb_ltpi_selftest_runner;
   localparam int N    = 4;
   localparam int MAXC = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, start, parallel_mode, stop_on_fail;
   logic [N-1:0]  test_enable;
   logic [15:0]   timeout_cycles;
   logic [N-1:0]  tc_start, tc_done, tc_pass;
   logic          busy, done, suite_pass, result_valid;
   logic [N-1:0]  pass_mask, fail_mask, timeout_mask;
   logic [1:0]    current_test;
   logic [5:0]    tests_run;

   int n_total = 0;
   int n_bad   = 0;

   // Per-channel responder behaviour: d_cfg = cycles after tc_start until tc_done (0 = silent)
   int d_cfg[N];
   bit p_cfg[N];

   // Reference timeline
   int           launch_cyc[N];
   logic [N-1:0] exp_start[MAXC];
   int           exp_done_cyc;
   logic [N-1:0] exp_pass, exp_fail, exp_tmo;
   int           exp_run;
   logic         exp_sp;

   ltpi_selftest_runner #(.NUM_TESTS(N), .TO_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .parallel_mode(parallel_mode),
      .stop_on_fail(stop_on_fail), .test_enable(test_enable), .timeout_cycles(timeout_cycles),
      .tc_start(tc_start), .tc_done(tc_done), .tc_pass(tc_pass), .busy(busy), .done(done),
      .suite_pass(suite_pass), .result_valid(result_valid), .pass_mask(pass_mask),
      .fail_mask(fail_mask), .timeout_mask(timeout_mask), .current_test(current_test),
      .tests_run(tests_run)
   );

   // Cycle 1 is the cycle after the accepting edge. A test launched in cycle L resolves in
   // cycle L+d when d <= t (or t == 0), otherwise by timeout in cycle L+t.
   task automatic compute_model(input bit par, input bit sof, input logic [N-1:0] en,
                                input int t);
      int  cyc, r, last;
      bit  stop;
      for (int c = 0; c < MAXC; c++) exp_start[c] = '0;
      exp_pass = '0; exp_fail = '0; exp_tmo = '0; exp_run = 0;
      last = 0; cyc = 1; stop = 1'b0;
      for (int i = 0; i < N; i++) begin
         launch_cyc[i] = -1;
         if (en[i] && !stop) begin
            launch_cyc[i] = par ? 1 : cyc;
            if (d_cfg[i] > 0 && (t == 0 || d_cfg[i] <= t)) begin
               r = launch_cyc[i] + d_cfg[i];
               if (p_cfg[i]) exp_pass[i] = 1'b1;
               else          exp_fail[i] = 1'b1;
            end else begin
               r = launch_cyc[i] + t;
               exp_fail[i] = 1'b1;
               exp_tmo[i]  = 1'b1;
            end
            exp_run++;
            exp_start[launch_cyc[i]][i] = 1'b1;
            if (r > last) last = r;
            cyc = r + 1;
            if (!par && sof && exp_fail[i]) stop = 1'b1;
         end
      end
      exp_done_cyc = last + 1;
      exp_sp = (exp_fail == '0) && (exp_run == $countones(en)) && (exp_run != 0);
   endtask

   task automatic run_suite(input string name, input bit par, input bit sof,
                            input logic [N-1:0] en, input int t, input bit noisy);
      logic [N-1:0] es;
      int           idx;
      compute_model(par, sof, en, t);
      @(negedge clk);
      parallel_mode = par; stop_on_fail = sof; test_enable = en;
      timeout_cycles = 16'(t); start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= exp_done_cyc + 1; c++) begin
         @(negedge clk);
         start = 1'b0;
         tc_done = '0;
         tc_pass = N'($urandom);
         es = (c < MAXC) ? exp_start[c] : '0;
         n_total++;
         if (tc_start !== es) begin
            n_bad++;
            $display("FAIL %s c=%0d tc_start got=%b exp=%b", name, c, tc_start, es);
         end
         n_total++;
         if (done !== (c == exp_done_cyc)) begin
            n_bad++;
            $display("FAIL %s c=%0d done got=%b exp=%b", name, c, done, c == exp_done_cyc);
         end
         n_total++;
         if (busy !== (c < exp_done_cyc)) begin
            n_bad++;
            $display("FAIL %s c=%0d busy got=%b exp=%b", name, c, busy, c < exp_done_cyc);
         end
         n_total++;
         if (result_valid !== (c >= exp_done_cyc)) begin
            n_bad++;
            $display("FAIL %s c=%0d result_valid got=%b exp=%b", name, c, result_valid,
                     c >= exp_done_cyc);
         end
         n_total++;
         if (suite_pass !== ((c >= exp_done_cyc) ? exp_sp : 1'b0)) begin
            n_bad++;
            $display("FAIL %s c=%0d suite_pass got=%b exp=%b", name, c, suite_pass,
                     (c >= exp_done_cyc) ? exp_sp : 1'b0);
         end
         if (en != '0 && (par || es != '0)) begin
            idx = 0;
            for (int i = N - 1; i >= 0; i--) if (es[i]) idx = i;
            if (par) idx = 0;
            n_total++;
            if (current_test !== 2'(idx)) begin
               n_bad++;
               $display("FAIL %s c=%0d current_test got=%0d exp=%0d", name, c, current_test, idx);
            end
         end
         if (c >= exp_done_cyc) begin
            n_total++;
            if ({pass_mask, fail_mask, timeout_mask} !== {exp_pass, exp_fail, exp_tmo}) begin
               n_bad++;
               $display("FAIL %s c=%0d masks pass/fail/tmo got=%b/%b/%b exp=%b/%b/%b", name, c,
                        pass_mask, fail_mask, timeout_mask, exp_pass, exp_fail, exp_tmo);
            end
            n_total++;
            if (tests_run !== 6'(exp_run)) begin
               n_bad++;
               $display("FAIL %s c=%0d tests_run got=%0d exp=%0d", name, c, tests_run, exp_run);
            end
         end
         if (c <= exp_done_cyc) begin
            for (int i = 0; i < N; i++) begin
               if (!en[i]) begin
                  tc_done[i] = ($urandom % 4) == 0;  // ignored: channel not enabled
               end else if (launch_cyc[i] >= 0 && d_cfg[i] > 0) begin
                  if (c == launch_cyc[i] + d_cfg[i]) begin
                     tc_done[i] = 1'b1;
                     tc_pass[i] = p_cfg[i];
                  end else if (par && c == launch_cyc[i] + d_cfg[i] + 2) begin
                     tc_done[i] = 1'b1;  // repeat done with flipped verdict must be ignored
                     tc_pass[i] = ~p_cfg[i];
                  end
               end
            end
            if (noisy) begin
               start = 1'($urandom);
               parallel_mode = 1'($urandom);
               stop_on_fail = 1'($urandom);
               test_enable = N'($urandom);
               timeout_cycles = 16'($urandom_range(1, 5));
            end
         end
      end
      tc_done = '0;
      start = 1'b0;
   endtask

   task automatic set_resp(input int d0, input int d1, input int d2, input int d3,
                           input logic [N-1:0] p);
      d_cfg[0] = d0; d_cfg[1] = d1; d_cfg[2] = d2; d_cfg[3] = d3;
      for (int i = 0; i < N; i++) p_cfg[i] = p[i];
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; parallel_mode = 1'b0; stop_on_fail = 1'b0;
      test_enable = '0; timeout_cycles = '0; tc_done = '0; tc_pass = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({tc_start, busy, done, suite_pass, result_valid, pass_mask, fail_mask, timeout_mask,
           current_test, tests_run} !== '0) begin
         n_bad++;
         $display("FAIL reset outputs got tc_start=%b busy=%b done=%b sp=%b rv=%b run=%0d exp=0",
                  tc_start, busy, done, suite_pass, result_valid, tests_run);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_seq_all_pass;
      set_resp(5, 5, 5, 5, 4'b1111);
      run_suite("seq_all_pass", 1'b0, 1'b0, 4'b1111, 100, 1'b0);
   endtask

   task automatic test_skip_stop;
      set_resp(2, 3, 6, 4, 4'b1101);
      run_suite("skip_stop", 1'b0, 1'b1, 4'b1011, 50, 1'b0);
   endtask

   task automatic test_timeout;
      set_resp(0, 3, 3, 3, 4'b1111);
      run_suite("timeout_silent", 1'b0, 1'b0, 4'b1111, 10, 1'b0);
      set_resp(10, 11, 9, 1, 4'b1111);
      run_suite("timeout_edge", 1'b0, 1'b0, 4'b1111, 10, 1'b0);
   endtask

   task automatic test_parallel_timeout;
      set_resp(5, 0, 7, 0, 4'b1111);
      run_suite("par_timeout", 1'b1, 1'b0, 4'b1111, 20, 1'b0);
   endtask

   task automatic test_empty_and_ignored;
      set_resp(1, 1, 1, 1, 4'b1111);
      run_suite("empty_seq", 1'b0, 1'b0, 4'b0000, 10, 1'b0);
      run_suite("empty_par", 1'b1, 1'b0, 4'b0000, 10, 1'b0);
      set_resp(4, 2, 6, 3, 4'b1011);
      run_suite("ignored_start_seq", 1'b0, 1'b0, 4'b1111, 30, 1'b1);
      run_suite("ignored_start_par", 1'b1, 1'b0, 4'b1110, 30, 1'b1);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      parallel_mode = 1'b0; stop_on_fail = 1'b0; test_enable = 4'b1100;
      timeout_cycles = 16'd50; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (busy !== 1'b1 || current_test !== 2'd2) begin
         n_bad++;
         $display("FAIL reset_mid pre busy/current_test got=%b/%0d exp=1/2", busy, current_test);
      end
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({tc_start, busy, done, suite_pass, result_valid, pass_mask, fail_mask, timeout_mask,
           current_test, tests_run} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid outputs got busy=%b done=%b ct=%0d run=%0d exp=0", busy, done,
                  current_test, tests_run);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid post done/busy got=%b/%b exp=0/0", done, busy);
      end
      set_resp(3, 2, 4, 5, 4'b1111);
      run_suite("after_reset", 1'b0, 1'b0, 4'b1100, 50, 1'b0);
   endtask

   task automatic test_random;
      bit           par, sof, noisy;
      logic [N-1:0] en;
      int           t;
      for (int k = 0; k < 40; k++) begin
         par = 1'($urandom); sof = 1'($urandom); noisy = 1'($urandom);
         en = N'($urandom);
         t = $urandom_range(3, 30);
         for (int i = 0; i < N; i++) begin
            d_cfg[i] = (($urandom % 5) == 0) ? 0 : $urandom_range(1, t + 4);
            p_cfg[i] = ($urandom % 4) != 0;
         end
         if (($urandom % 6) == 0) begin
            t = 0;  // timeout disabled: every channel must answer
            for (int i = 0; i < N; i++) d_cfg[i] = $urandom_range(1, 12);
         end
         run_suite("random", par, sof, en, t, noisy);
      end
   endtask

   initial begin
      test_reset();
      test_seq_all_pass();
      test_skip_stop();
      test_timeout();
      test_parallel_timeout();
      test_empty_and_ignored();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ltpi_selftest_runner.md
Name: ltpi_selftest_runner

Overview:
- Synthesizable multi-testcase runner for on-chip LTPI PHY TX/RX self-test.
- Launches up to NUM_TESTS testcase engines, either sequentially or in parallel, with a per-test cycle timeout.
- Aggregates per-test pass/fail/timeout into masks and a single suite verdict.
- Sits between the management CSR block (config and start) and the PHY loopback/pattern-checker engines (tc_* handshake).

Parameters:
- NUM_TESTS, 4: number of testcase channels, legal range 1..32.
- TO_W, 16: width of the timeout counter and of timeout_cycles.
- IDX_W, $clog2(NUM_TESTS) (minimum 1): width of current_test.

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- start  in  1  suite start request, one-cycle pulse
- parallel_mode  in  1  1 = launch all enabled tests together; 0 = sequential, lowest index first
- stop_on_fail  in  1  sequential mode only: abort the suite after the first failure
- test_enable  in  NUM_TESTS  enables each test channel
- timeout_cycles  in  TO_W  per-test timeout; 0 disables the timeout
- tc_start  out  NUM_TESTS  one-cycle launch pulse per channel
- tc_done  in  NUM_TESTS  testcase completion pulse
- tc_pass  in  NUM_TESTS  verdict, valid in the same cycle as tc_done
- busy  out  1  suite in progress
- done  out  1  one-cycle pulse when the suite finishes
- suite_pass  out  1  overall verdict, valid while result_valid is high
- result_valid  out  1  high from done until the next accepted start
- pass_mask  out  NUM_TESTS  tests that passed
- fail_mask  out  NUM_TESTS  tests that failed, including timeouts
- timeout_mask  out  NUM_TESTS  tests that failed by timeout
- current_test  out  IDX_W  index of the test in flight (sequential mode)
- tests_run  out  6  count of tests that completed or timed out

Behaviour:
- Reset (reset_n = 0 at a clk edge): FSM goes to IDLE. Every output is 0, including all masks, tests_run and current_test. Reset mid-suite aborts with no done pulse; tc_start drops immediately.
- FSM states are IDLE, SEQ_LAUNCH, SEQ_WAIT, PAR_WAIT and REPORT.
- Start handling:
  - start is accepted only in IDLE; start while busy is ignored.
  - On acceptance, parallel_mode, stop_on_fail, test_enable and timeout_cycles are latched. Later changes to these inputs have no effect until the next start.
  - Acceptance clears all masks, tests_run and result_valid, and sets busy.
- Empty suite: if the latched test_enable is 0, go straight to REPORT. done pulses in cycle t+1 with suite_pass = 0.
- Sequential mode:
  - Start is accepted at edge t. tc_start[i] is high for exactly cycle t+1, where i is the lowest enabled index; current_test = i.
  - SEQ_WAIT monitors tc_done[i] only. tc_done on any non-active channel is ignored.
  - tc_done[i] in cycle k: record tc_pass[i] into pass_mask or fail_mask and increment tests_run. Then either pulse tc_start for the next enabled index in cycle k+1, or enter REPORT with done high in cycle k+1.
  - Timeout: the timer is cleared at launch and counts the cycles after the tc_start cycle. If no tc_done arrives within timeout_cycles cycles, then in the last of those cycles set fail_mask[i] and timeout_mask[i], increment tests_run, and proceed exactly as for a done. If tc_done and expiry fall in the same cycle, tc_done wins.
  - stop_on_fail = 1 and any failure: go to REPORT. Unrun tests remain 0 in all masks.
- Parallel mode:
  - tc_start pulses for all enabled channels together in cycle t+1. current_test stays 0.
  - Each channel's first tc_done is recorded; repeat tc_done on an already-recorded channel is ignored.
  - A single shared timer runs. On expiry, all still-pending enabled channels get fail and timeout bits set simultaneously, and tests_run is incremented by their count.
  - REPORT is entered in the cycle after the last pending channel resolves.
  - stop_on_fail is ignored in parallel mode.
- REPORT lasts one cycle: done = 1, busy drops to 0 in the same cycle, result_valid rises. Return to IDLE.
- suite_pass = 1 iff fail_mask == 0 and tests_run == popcount(latched test_enable) and tests_run != 0.
- Outputs are held stable in IDLE until the next accepted start.

Test Plan:
- Sequential all pass: NUM_TESTS = 4, enable 4'b1111, timeout 100; each test returns done+pass 5 cycles after its tc_start -> tc_start pulses in order 0..3, each exactly 1 cycle wide; done pulses; pass_mask 4'b1111; tests_run 4; suite_pass 1.
- Skip and stop_on_fail: enable 4'b1011, stop_on_fail 1, test 1 fails -> channel 3 is never started; pass_mask 4'b0001, fail_mask 4'b0010, tests_run 2, suite_pass 0.
- Timeout: timeout 10, test 0 never responds -> timeout_mask[0] set exactly 10 cycles after the tc_start cycle; then test 1 is launched in the next cycle. Separately, a done arriving in the expiry cycle -> recorded as pass, not timeout.
- Parallel with timeout: parallel_mode 1, enable 4'b1111, tests 0 and 2 pass, 1 and 3 silent, timeout 20 -> all tc_start in the same cycle; fail_mask 4'b1010; timeout_mask 4'b1010; tests_run 4; suite_pass 0.
- Empty and ignored start: enable 0 -> done pulses 1 cycle after start with suite_pass 0. A start pulse during busy -> no relaunch and no change to results.
- Reset mid-suite: assert reset_n = 0 during SEQ_WAIT -> next cycle all outputs are 0 with no done pulse; a fresh start runs the suite correctly.
